// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART frame parser: FSM states, frame geometry
// and the saturating error-counter increment.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      FUNC = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      TAIL = 3'd4
   } state_t;

   localparam int unsigned FRAME_DATA_BYTES    = 10;
   localparam logic [7:0]  DEFAULT_HEADER      = 8'h55;
   localparam logic [7:0]  DEFAULT_TAIL        = 8'hAA;
   localparam int unsigned DEFAULT_TIMEOUT_CYC = 50000;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte stream from the UART receiver: one data byte qualified by a one-cycle strobe.
interface uart_frame_parser_if;

   logic [7:0] uart_data;
   logic       uart_done;

   modport master (output uart_data, output uart_done);
   modport slave  (input  uart_data, input  uart_done);

endinterface

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog: counts strobe-free cycles while enabled, pulses expire when the
// count reaches _TIMEOUT_CYC-1. A kick in the expiry cycle wins and suppresses the pulse.
module uart_frame_timeout #(
   parameter int unsigned _TIMEOUT_CYC = 50000
) (
   input  logic clk_50M,
   input  logic rst_n,
   input  logic enable,
   input  logic kick,
   output logic expire
);

   localparam int unsigned    CW   = $clog2(_TIMEOUT_CYC);
   localparam logic [CW-1:0]  LAST = CW'(_TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;

   assign expire = enable && !kick && (cnt == LAST);

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!enable || kick || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_frame_parser.sv
// Frames the UART byte stream (header, func, 10 data, checksum, tail), publishes good
// frames with a one-cycle pack_done and drops bad or stalled frames with pack_err.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter logic [7:0]  _HEADER      = DEFAULT_HEADER,
   parameter logic [7:0]  _TAIL        = DEFAULT_TAIL,
   parameter int unsigned _TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
   input  logic                clk_50M,
   input  logic                rst_n,
   uart_frame_parser_if.slave  rx,
   output logic [7:0]          func_reg,
   output logic [7:0]          rev_data1,
   output logic [7:0]          rev_data2,
   output logic [7:0]          rev_data3,
   output logic [7:0]          rev_data4,
   output logic [7:0]          rev_data5,
   output logic [7:0]          rev_data6,
   output logic [7:0]          rev_data7,
   output logic [7:0]          rev_data8,
   output logic [7:0]          rev_data9,
   output logic [7:0]          rev_data10,
   output logic                pack_done,
   output logic                pack_err,
   output logic [7:0]          err_cnt
);

   localparam logic [3:0] LAST_IDX = 4'(FRAME_DATA_BYTES - 1);

   state_t     state, state_d;
   logic [3:0] idx, idx_d;
   logic [7:0] sum, sum_d;
   logic [7:0] shadow_func;
   logic [7:0] shadow [FRAME_DATA_BYTES];
   logic       func_we, data_we, commit, err;
   logic       expire;

   uart_frame_timeout #(
      ._TIMEOUT_CYC(_TIMEOUT_CYC)
   ) u_timeout (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .enable  (state != IDLE),
      .kick    (rx.uart_done),
      .expire  (expire)
   );

   always_comb begin
      state_d = state;
      idx_d   = idx;
      sum_d   = sum;
      func_we = 1'b0;
      data_we = 1'b0;
      commit  = 1'b0;
      err     = 1'b0;
      if (rx.uart_done) begin
         // Error-terminating bytes return to IDLE without being re-examined as a header.
         unique case (state)
            IDLE: if (rx.uart_data == _HEADER) state_d = FUNC;
            FUNC: begin
               func_we = 1'b1;
               sum_d   = rx.uart_data;
               idx_d   = '0;
               state_d = DATA;
            end
            DATA: begin
               data_we = 1'b1;
               sum_d   = sum + rx.uart_data;
               if (idx == LAST_IDX) state_d = CSUM;
               else                 idx_d   = idx + 4'd1;
            end
            CSUM: begin
               if (rx.uart_data == sum) begin
                  state_d = TAIL;
               end else begin
                  err     = 1'b1;
                  state_d = IDLE;
               end
            end
            TAIL: begin
               commit  = (rx.uart_data == _TAIL);
               err     = (rx.uart_data != _TAIL);
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (expire) begin
         err     = 1'b1;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         sum         <= '0;
         shadow_func <= '0;
         for (int unsigned i = 0; i < FRAME_DATA_BYTES; i++) shadow[i] <= '0;
         func_reg    <= '0;
         rev_data1   <= '0;
         rev_data2   <= '0;
         rev_data3   <= '0;
         rev_data4   <= '0;
         rev_data5   <= '0;
         rev_data6   <= '0;
         rev_data7   <= '0;
         rev_data8   <= '0;
         rev_data9   <= '0;
         rev_data10  <= '0;
         pack_done   <= 1'b0;
         pack_err    <= 1'b0;
         err_cnt     <= '0;
      end else begin
         state     <= state_d;
         idx       <= idx_d;
         sum       <= sum_d;
         pack_done <= commit;
         pack_err  <= err;
         if (func_we) shadow_func <= rx.uart_data;
         if (data_we) shadow[idx] <= rx.uart_data;
         if (err)     err_cnt     <= sat_inc(err_cnt);
         if (commit) begin
            func_reg   <= shadow_func;
            rev_data1  <= shadow[0];
            rev_data2  <= shadow[1];
            rev_data3  <= shadow[2];
            rev_data4  <= shadow[3];
            rev_data5  <= shadow[4];
            rev_data6  <= shadow[5];
            rev_data7  <= shadow[6];
            rev_data8  <= shadow[7];
            rev_data9  <= shadow[8];
            rev_data10 <= shadow[9];
         end
      end
   end

endmodule
